// File: rtl/dither_sram_arbiter.sv
// Arbitrates the single-port image SRAM between the SPI loader, the dithering engine and the
// debug query port. The engine can lock the RAM for RMW bursts, and a starved query is promoted.
module dither_sram_arbiter #(
  parameter int IMAGE_ADDR_WIDTH = 16,
  parameter int RGB_SIZE         = 8,
  parameter int RD_LATENCY       = 2,
  parameter int STARVE_LIMIT     = 64,
  parameter int LOCK_MAX         = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_req,
  input  logic [IMAGE_ADDR_WIDTH-1:0] ld_addr,
  input  logic [RGB_SIZE-1:0]         ld_wdata,
  output logic                        ld_gnt,
  input  logic                        eng_req,
  input  logic                        eng_we,
  input  logic                        eng_lock,
  input  logic [IMAGE_ADDR_WIDTH-1:0] eng_addr,
  input  logic [RGB_SIZE-1:0]         eng_wdata,
  output logic                        eng_gnt,
  output logic                        eng_rvalid,
  output logic [RGB_SIZE-1:0]         eng_rdata,
  input  logic                        q_req,
  input  logic [IMAGE_ADDR_WIDTH-1:0] q_addr,
  output logic                        q_gnt,
  output logic                        q_rvalid,
  output logic [RGB_SIZE-1:0]         q_rdata,
  output logic [IMAGE_ADDR_WIDTH-1:0] ram_addr,
  output logic                        ram_we,
  output logic [RGB_SIZE-1:0]         ram_wdata,
  input  logic [RGB_SIZE-1:0]         ram_q,
  output logic                        lock_err
);

  // Handshake: each requester holds req/addr/data stable until gnt; a transfer happens at the
  // clock edge where req & gnt are both high. At most one gnt is high in any cycle.

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int LOCK_W   = $clog2(LOCK_MAX + 1);

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_ENG  = 2'b01;
  localparam logic [1:0] TAG_Q    = 2'b10;

  logic                        lock_active;
  logic [LOCK_W-1:0]           lock_cnt;
  logic [STARVE_W-1:0]         starve_cnt;
  logic                        promoted;
  logic [1:0]                  tag_pipe [RD_LATENCY];
  logic [1:0]                  push_tag;
  logic [1:0]                  exit_tag;
  logic [IMAGE_ADDR_WIDTH-1:0] last_addr;
  logic [RGB_SIZE-1:0]         last_wdata;

  assign promoted = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
  assign exit_tag = tag_pipe[RD_LATENCY-1];

  always_comb begin
    ld_gnt  = 1'b0;
    eng_gnt = 1'b0;
    q_gnt   = 1'b0;
    if (!rst) begin
      // A held lock shuts everyone else out, even a promoted query.
      if (lock_active)          eng_gnt = eng_req;
      else if (promoted && q_req) q_gnt = 1'b1;
      else if (ld_req)          ld_gnt  = 1'b1;
      else if (eng_req)         eng_gnt = 1'b1;
      else if (q_req)           q_gnt   = 1'b1;
    end
  end

  always_comb begin
    ram_addr  = rst ? '0 : last_addr;
    ram_wdata = rst ? '0 : last_wdata;
    ram_we    = 1'b0;
    push_tag  = TAG_NONE;
    if (ld_gnt) begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_we    = 1'b1;
    end else if (eng_gnt) begin
      ram_addr  = eng_addr;
      ram_wdata = eng_wdata;
      ram_we    = eng_we;
      push_tag  = eng_we ? TAG_NONE : TAG_ENG;
    end else if (q_gnt) begin
      ram_addr  = q_addr;
      push_tag  = TAG_Q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      lock_err    <= 1'b0;
      starve_cnt  <= '0;
      last_addr   <= '0;
      last_wdata  <= '0;
      eng_rvalid  <= 1'b0;
      q_rvalid    <= 1'b0;
      eng_rdata   <= '0;
      q_rdata     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      if (ld_gnt || eng_gnt || q_gnt) begin
        last_addr  <= ram_addr;
        last_wdata <= ram_wdata;
      end

      // Timeout wins over a same-cycle beat: the beat still goes out, the lock does not survive.
      if (lock_active) begin
        lock_cnt <= lock_cnt + 1'b1;
        if (lock_cnt == LOCK_W'(LOCK_MAX - 1)) begin
          lock_active <= 1'b0;
          lock_err    <= 1'b1;
        end else if (eng_gnt && !eng_lock) begin
          lock_active <= 1'b0;
        end
      end else if (eng_gnt && eng_lock) begin
        lock_active <= 1'b1;
        lock_cnt    <= '0;
      end

      if (q_req && !q_gnt) begin
        if (!promoted) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end

      tag_pipe[0] <= push_tag;
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];

      eng_rvalid <= (exit_tag == TAG_ENG);
      q_rvalid   <= (exit_tag == TAG_Q);
      if (exit_tag == TAG_ENG) eng_rdata <= ram_q;
      if (exit_tag == TAG_Q)   q_rdata   <= ram_q;
    end
  end

endmodule

// File: doc/dither_sram_arbiter.md
Name: dither_sram_arbiter

Overview:
- Shares the single-port image SRAM (IMAGE_SIZE x RGB_SIZE) between three requesters:
  - the SPI pixel loader (write-only),
  - the Floyd-Steinberg error-diffusion engine (read/write),
  - the debug query port driven by switches/key (read-only).
- Issues at most one RAM command per cycle and routes read data back to the issuing requester.
- Gives the engine an exclusive lock for its 4-neighbour read-modify-write bursts.
- Prevents the query port from starving.

Parameters:
- IMAGE_ADDR_WIDTH, 16, SRAM address width.
- RGB_SIZE, 8, pixel data width.
- RD_LATENCY, 2, cycles from an accepted read command to valid ram_q.
- STARVE_LIMIT, 64, cycles a pending query may wait before it is promoted.
- LOCK_MAX, 32, maximum cycles the engine lock may be held.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- ld_req  in  1  loader write request.
- ld_addr  in  IMAGE_ADDR_WIDTH  loader address.
- ld_wdata  in  RGB_SIZE  loader write data.
- ld_gnt  out  1  loader command accepted this cycle.
- eng_req  in  1  engine request.
- eng_we  in  1  engine write (1) / read (0).
- eng_lock  in  1  hold exclusive access after this beat.
- eng_addr  in  IMAGE_ADDR_WIDTH  engine address.
- eng_wdata  in  RGB_SIZE  engine write data.
- eng_gnt  out  1  engine command accepted.
- eng_rvalid  out  1  engine read data valid.
- eng_rdata  out  RGB_SIZE  engine read data.
- q_req  in  1  query read request.
- q_addr  in  IMAGE_ADDR_WIDTH  query address.
- q_gnt  out  1  query command accepted.
- q_rvalid  out  1  query read data valid.
- q_rdata  out  RGB_SIZE  query read data.
- ram_addr  out  IMAGE_ADDR_WIDTH  SRAM address.
- ram_we  out  1  SRAM write enable.
- ram_wdata  out  RGB_SIZE  SRAM write data.
- ram_q  in  RGB_SIZE  SRAM read data.
- lock_err  out  1  sticky flag: lock timed out.

Behaviour:
- Handshake: a requester holds req and its addr/data stable until it sees gnt. A transfer occurs at the clock edge where req&gnt=1. gnt is combinational from the current req and registered arbiter state. At most one gnt is high per cycle.
- ram_addr/ram_we/ram_wdata are combinationally muxed from the granted requester. With no grant, ram_we=0 and ram_addr/ram_wdata hold the last issued values.
- Grant priority, normal: loader > engine > query.
- Grant priority, query promoted (starve_cnt >= STARVE_LIMIT): query > loader > engine, for exactly one grant.
- Grant priority, lock_active=1: only the engine may be granted; ld_gnt=q_gnt=0 regardless of promotion.
- Lock:
  - lock_active sets on an accepted engine beat with eng_lock=1.
  - lock_active clears on an accepted engine beat with eng_lock=0.
  - lock_cnt increments each cycle lock_active=1 and resets to 0 on set.
  - When lock_cnt reaches LOCK_MAX, lock_active is forced to 0 and lock_err sets. lock_err holds until rst.
- starve_cnt:
  - increments (saturating) each cycle q_req=1 and q_gnt=0,
  - clears when q_gnt=1 or q_req=0.
- Read return: an accepted read pushes a 2-bit tag (01=engine, 10=query) into an RD_LATENCY-deep shift register; writes push 00.
  - When a tag exits, the matching rvalid pulses for one cycle and its rdata is driven with ram_q.
  - rdata holds its last value when rvalid=0.
  - Reads return in issue order.
  - Engine read-after-write to the same address returns the new data; single-port order makes this inherent.
- Latency: a read accepted at edge N gives rvalid high during the cycle after edge N+RD_LATENCY.
- Reset:
  - gnt outputs=0 while rst=1.
  - eng_rvalid=q_rvalid=0, tag pipe cleared, rdata=0.
  - lock_active=0, lock_cnt=0, starve_cnt=0, lock_err=0.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - Reads in flight at reset are discarded; no rvalid follows.
- Simultaneous events:
  - Promoted query and loader in the same cycle: query wins.
  - Lock set and query promotion in the same cycle: the engine beat wins, and the promotion waits for lock release.
  - Lock timeout and an engine beat in the same cycle: the beat is accepted, then the lock is cleared regardless of eng_lock.
- Address wrap: none. Addresses pass through unmodified.

Test Plan:
- Reset then ld_req with addr 0..3 and data 10,11,12,13 → ld_gnt high 4 consecutive cycles; then q_req addr 2 → q_rvalid 2 cycles after grant with q_rdata=12.
- ld_req and eng_req held together for 5 cycles → ld_gnt all 5 cycles, eng_gnt 0; eng_gnt on the 6th cycle after ld_req drops.
- Engine locked burst: read A, read B, write A=0x55 (lock=1), write B=0x66 (lock=0), with ld_req and q_req held → only eng_gnt until the unlock beat; ld_gnt next cycle; rdata order A then B.
- eng_req held continuously, q_req high → q_gnt asserted exactly once after 64 waiting cycles, then starve_cnt=0.
- eng_lock=1 beat, then eng_req low for 40 cycles → lock released at cycle 32, lock_err=1, ld_gnt resumes; lock_err stays 1 until rst.
- Engine read accepted, rst asserted the next cycle for 1 cycle → no eng_rvalid for 5 cycles; all outputs at reset values.
